// File: rtl/ws2812_pkg.sv
// ws2812_pkg: timing and state definitions shared by the WS2812 driver and
// receiver so both ends of the link derive their cycle counts the same way.
//   ns_to_cycles() : ceiling conversion of a duration in ns to clock cycles
//   T*_NS          : driver pulse timing (0-bit high, 1-bit high, bit period,
//                    latch/reset gap)
//   RX_*_NS        : receiver classification limits
//   rx_state_t     : receiver FSM encoding
package ws2812_pkg;

  function automatic int ns_to_cycles(input int clk_mhz, input int ns);
    return (clk_mhz * ns + 999) / 1000;
  endfunction

  // Driver timing.
  localparam int T0H_NS      = 350;
  localparam int T1H_NS      = 850;
  localparam int T_PERIOD_NS = 1250;
  localparam int T_RESET_NS  = 50000;

  // Receiver classification limits.
  localparam int RX_MIN_HIGH_NS = 150;
  localparam int RX_THRESH_NS   = 625;
  localparam int RX_MAX_HIGH_NS = 2500;

  localparam int PIXEL_BITS = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RECV  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/ws2812_rx_if.sv
// ws2812_rx_if: decoded-pixel output bundle of the WS2812 receiver.
//   pixel_rgb   : decoded pixel, first-received bit at [23]
//   pixel_index : position of the pixel in the current frame
//   pixel_valid : one-cycle strobe qualifying pixel_rgb / pixel_index
//   frame_done  : one-cycle strobe at the end of a clean frame
//   pixel_count : pixels in the last frame, valid with frame_done
//   bit_error   : one-cycle strobe on glitch, stuck-high or partial pixel
//   overflow    : one-cycle strobe per pixel beyond the frame capacity
// master = receiver (drives), slave = consumer.
interface ws2812_rx_if #(
  parameter int LED_BITS = 3
);
  logic [23:0]         pixel_rgb;
  logic [LED_BITS-1:0] pixel_index;
  logic                pixel_valid;
  logic                frame_done;
  logic [LED_BITS:0]   pixel_count;
  logic                bit_error;
  logic                overflow;

  modport master (
    output pixel_rgb, pixel_index, pixel_valid, frame_done,
           pixel_count, bit_error, overflow
  );

  modport slave (
    input  pixel_rgb, pixel_index, pixel_valid, frame_done,
           pixel_count, bit_error, overflow
  );
endinterface

// File: rtl/ws2812_sync_edge.sv
// ws2812_sync_edge: two-flop synchroniser for an asynchronous input plus
// rise/fall detection against a registered copy of the synchronised level.
//   clk, reset : clock, synchronous active-high reset
//   din        : asynchronous input
//   din_s      : synchronised level
//   rise, fall : single-cycle edge indications, aligned with din_s
module ws2812_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic dly_q,  dly_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    dly_d  = sync_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign din_s = sync_q;
  assign rise  = sync_q & ~dly_q;
  assign fall  = ~sync_q & dly_q;

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: decodes a WS2812 single-wire stream into 24-bit pixels.
// Each high pulse is measured; short pulses are glitches, long ones are
// stuck-high, otherwise the length against a threshold gives the bit value.
// Bits are assembled MSB first; a long low gap ends the frame.
//   clk, reset : clock, synchronous active-high reset
//   din        : asynchronous serial input
//   rx         : decoded pixel / frame / error outputs (master side)
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int CLK_MHZ  = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  ws2812_rx_if.master rx
);

  localparam int LED_BITS = $clog2(NUM_LEDS);
  localparam int T_GAP    = CLK_MHZ * 50;
  localparam int CNT_W    = $clog2(T_GAP + 1);

  localparam logic [CNT_W-1:0] MIN_HIGH_C = CNT_W'(ns_to_cycles(CLK_MHZ, RX_MIN_HIGH_NS));
  localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(ns_to_cycles(CLK_MHZ, RX_THRESH_NS));
  localparam logic [CNT_W-1:0] MAX_HIGH_C = CNT_W'(ns_to_cycles(CLK_MHZ, RX_MAX_HIGH_NS));
  localparam logic [CNT_W-1:0] GAP_C      = CNT_W'(T_GAP);
  localparam logic [LED_BITS:0] NUM_LEDS_C = (LED_BITS + 1)'(NUM_LEDS);

  logic din_s, rise, fall;

  ws2812_sync_edge u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .din_s (din_s),
    .rise  (rise),
    .fall  (fall)
  );

  rx_state_t           state_q, state_d;
  logic [CNT_W-1:0]    hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0]    lo_cnt_q, lo_cnt_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [LED_BITS:0]   pix_cnt_q, pix_cnt_d;
  logic [23:0]         shift_q, shift_d;
  // Set the cycle after the 24th bit is shifted in; the word is published
  // from shift_q one cycle later through the output registers.
  logic                pend_q, pend_d;

  logic [23:0]         pixel_rgb_q, pixel_rgb_d;
  logic [LED_BITS-1:0] pixel_index_q, pixel_index_d;
  logic                pixel_valid_q, pixel_valid_d;
  logic                frame_done_q, frame_done_d;
  logic [LED_BITS:0]   pixel_count_q, pixel_count_d;
  logic                bit_error_q, bit_error_d;
  logic                overflow_q, overflow_d;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    shift_d       = shift_q;
    pend_d        = 1'b0;
    pixel_rgb_d   = pixel_rgb_q;
    pixel_index_d = pixel_index_q;
    pixel_count_d = pixel_count_q;
    pixel_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    bit_error_d   = 1'b0;
    overflow_d    = 1'b0;

    // Level counters run in every state; each clears on the opposite level.
    if (din_s) begin
      hi_cnt_d = (hi_cnt_q == MAX_HIGH_C) ? hi_cnt_q : hi_cnt_q + 1'b1;
      lo_cnt_d = '0;
    end else begin
      hi_cnt_d = '0;
      lo_cnt_d = (lo_cnt_q == GAP_C) ? lo_cnt_q : lo_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // Only a full gap arms the decoder, so a stream already running
        // when we come out of reset is never half-decoded.
        if (lo_cnt_q == GAP_C) state_d = ST_ARMED;
      end

      ST_ARMED: begin
        if (rise) begin
          state_d   = ST_RECV;
          bit_cnt_d = '0;
          pix_cnt_d = '0;
        end
      end

      ST_RECV: begin
        if (fall && (hi_cnt_q < MIN_HIGH_C)) begin
          bit_error_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (hi_cnt_q == MAX_HIGH_C) begin
          bit_error_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (lo_cnt_q == GAP_C) begin
          if (bit_cnt_q == 5'd0) begin
            frame_done_d  = 1'b1;
            pixel_count_d = pix_cnt_q;
          end else begin
            bit_error_d = 1'b1;
          end
          state_d = ST_ARMED;
        end else begin
          if (fall) begin
            shift_d = {shift_q[22:0], (hi_cnt_q >= THRESH_C)};
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = '0;
              pend_d    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          if (pend_q) begin
            if (pix_cnt_q < NUM_LEDS_C) begin
              pixel_valid_d = 1'b1;
              pixel_rgb_d   = shift_q;
              pixel_index_d = pix_cnt_q[LED_BITS-1:0];
              pix_cnt_d     = pix_cnt_q + 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      hi_cnt_q      <= '0;
      lo_cnt_q      <= '0;
      bit_cnt_q     <= '0;
      pix_cnt_q     <= '0;
      shift_q       <= '0;
      pend_q        <= 1'b0;
      pixel_rgb_q   <= '0;
      pixel_index_q <= '0;
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      pixel_count_q <= '0;
      bit_error_q   <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_cnt_q      <= hi_cnt_d;
      lo_cnt_q      <= lo_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      shift_q       <= shift_d;
      pend_q        <= pend_d;
      pixel_rgb_q   <= pixel_rgb_d;
      pixel_index_q <= pixel_index_d;
      pixel_valid_q <= pixel_valid_d;
      frame_done_q  <= frame_done_d;
      pixel_count_q <= pixel_count_d;
      bit_error_q   <= bit_error_d;
      overflow_q    <= overflow_d;
    end
  end

  assign rx.pixel_rgb   = pixel_rgb_q;
  assign rx.pixel_index = pixel_index_q;
  assign rx.pixel_valid = pixel_valid_q;
  assign rx.frame_done  = frame_done_q;
  assign rx.pixel_count = pixel_count_q;
  assign rx.bit_error   = bit_error_q;
  assign rx.overflow    = overflow_q;

endmodule
